// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle carried from vga_timing_gen to the pixel renderers.
// master = timing generator (drives everything); slave = renderer / VGA connector.
// Widths are fixed: 10-bit coordinates, 8-bit frame index.
interface vga_timing_gen_if;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       blank;
   logic       hs;
   logic       vs;
   logic       sof;
   logic [7:0] frame_count;

   modport master (
      output DrawX, DrawY, blank, hs, vs, sof, frame_count
   );

   modport slave (
      input  DrawX, DrawY, blank, hs, vs, sof, frame_count
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running hc/vc counters with all outputs registered.
// Outputs are decoded from next-state counters, so they align with DrawX/DrawY (0 latency).
// Optional macro SYNC_DELAY_EN adds one register on hs/vs so they lag the coordinates by one clock.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter bit HS_POL    = 1'b0,
   parameter bit VS_POL    = 1'b0
) (
   input  logic              vga_clk,
   input  logic              reset,
   vga_timing_gen_if.master  vga
);
   // Both totals must fit the 10-bit counters (<= 1024).
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [9:0] hc_q, hc_d;
   logic [9:0] vc_q, vc_d;
   logic [7:0] fc_q, fc_d;
   logic       blank_q, blank_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;
   logic       sof_q, sof_d;
   logic       wrap;

   // Next-state counters and output decode from the next-state position.
   always_comb begin
      hc_d    = hc_q + 10'd1;
      vc_d    = vc_q;
      fc_d    = fc_q;
      wrap    = (hc_q == H_LAST) && (vc_q == V_LAST);
      if (hc_q == H_LAST) begin
         hc_d = 10'd0;
         vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
      end
      if (wrap) begin
         fc_d = fc_q + 8'd1;
      end
      blank_d = (hc_d < H_VIS) && (vc_d < V_VIS);
      hs_d    = ((hc_d >= HS_START) && (hc_d <= HS_END)) ? HS_POL : ~HS_POL;
      vs_d    = ((vc_d >= VS_START) && (vc_d <= VS_END)) ? VS_POL : ~VS_POL;
      sof_d   = wrap;
   end

   // Reset parks the raster on the last pixel of a frame so the first edge wraps to (0,0) with sof.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         hc_q    <= H_LAST;
         vc_q    <= V_LAST;
         fc_q    <= 8'hFF;
         blank_q <= 1'b0;
         hs_q    <= ~HS_POL;
         vs_q    <= ~VS_POL;
         sof_q   <= 1'b0;
      end else begin
         hc_q    <= hc_d;
         vc_q    <= vc_d;
         fc_q    <= fc_d;
         blank_q <= blank_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         sof_q   <= sof_d;
      end
   end

   assign vga.DrawX       = hc_q;
   assign vga.DrawY       = vc_q;
   assign vga.blank       = blank_q;
   assign vga.sof         = sof_q;
   assign vga.frame_count = fc_q;

`ifdef SYNC_DELAY_EN
   logic hs_dly_q;
   logic vs_dly_q;

   // Extra sync stage so hs/vs line up with renderers that register RGB one clock later.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         hs_dly_q <= ~HS_POL;
         vs_dly_q <= ~VS_POL;
      end else begin
         hs_dly_q <= hs_q;
         vs_dly_q <= vs_q;
      end
   end

   assign vga.hs = hs_dly_q;
   assign vga.vs = vs_dly_q;
`else
   assign vga.hs = hs_q;
   assign vga.vs = vs_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-reset scoreboard bench for vga_timing_gen on a shrunken raster.
// Driver advances a pixel-index model and queues expected outputs every clock.
// Monitor pops and compares each clock, away from the active edge.
module tb_vga_timing_gen;
   localparam int HV = 8, HF = 2, HSY = 3, HB = 2;
   localparam int VV = 6, VF = 1, VSY = 2, VB = 2;
   localparam bit HPOL = 1'b0;
   localparam bit VPOL = 1'b1;
   localparam int HT = HV + HF + HSY + HB;
   localparam int VT = VV + VF + VSY + VB;
   localparam int FRAME = HT * VT;

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic       blank;
      logic       hs;
      logic       vs;
      logic       sof;
      logic [7:0] fc;
   } exp_t;

   logic vga_clk;
   logic reset;
   int   checks;
   int   errors;
   int   p;
   exp_t q[$];

   vga_timing_gen_if vif ();

   vga_timing_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
      .HS_POL(HPOL), .VS_POL(VPOL)
   ) dut (
      .vga_clk (vga_clk),
      .reset   (reset),
      .vga     (vif)
   );

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   // Sync levels for pixel index k (k < 0 means "not yet on the raster").
   function automatic logic hs_at(int k);
      int x;
      if (k < 0) return ~HPOL;
      x = k % HT;
      return (x >= HV + HF && x < HV + HF + HSY) ? HPOL : ~HPOL;
   endfunction

   function automatic logic vs_at(int k);
      int y;
      if (k < 0) return ~VPOL;
      y = (k / HT) % VT;
      return (y >= VV + VF && y < VV + VF + VSY) ? VPOL : ~VPOL;
   endfunction

   // Expected outputs when the raster is at pixel index k since the last reset release.
   function automatic exp_t model(int k);
      exp_t e;
      int x, y;
      if (k < 0) begin
         e.x = 10'(HT - 1); e.y = 10'(VT - 1); e.blank = 1'b0;
         e.sof = 1'b0; e.fc = 8'hFF;
      end else begin
         x = k % HT;
         y = (k / HT) % VT;
         e.x = 10'(x); e.y = 10'(y);
         e.blank = (x < HV) && (y < VV);
         e.sof = (k % FRAME) == 0;
         e.fc = 8'((k / FRAME) % 256);
      end
`ifdef SYNC_DELAY_EN
      e.hs = hs_at(k - 1);
      e.vs = vs_at(k - 1);
`else
      e.hs = hs_at(k);
      e.vs = vs_at(k);
`endif
      return e;
   endfunction

   // One clock of stimulus: advance the model on the edge, then drive reset between edges.
   task automatic step(input bit rst_next);
      @(posedge vga_clk);
      if (reset == 1'b0) p = p + 1;
      #2;
      reset = rst_next;
      if (rst_next) p = -1;
      q.push_back(model(p));
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at p=%0d t=%0t: got %0h expected %0h", name, p, $time, act, exp);
      end
   endtask

   // Monitor: one comparison set per clock, sampled 4 time units after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge vga_clk);
         #4;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL queue_empty at t=%0t: got 0 entries expected 1", $time);
         end else begin
            e = q.pop_front();
            chk("DrawX", 32'(vif.DrawX), 32'(e.x));
            chk("DrawY", 32'(vif.DrawY), 32'(e.y));
            chk("blank", 32'(vif.blank), 32'(e.blank));
            chk("hs", 32'(vif.hs), 32'(e.hs));
            chk("vs", 32'(vif.vs), 32'(e.vs));
            chk("sof", 32'(vif.sof), 32'(e.sof));
            chk("frame_count", 32'(vif.frame_count), 32'(e.fc));
         end
      end
   end

   // Driver: reset hold, 256+ frames for the frame counter wrap, then random mid-frame resets.
   initial begin
      int len;
      checks = 0;
      errors = 0;
      p = -1;
      reset = 1'b1;
      repeat (5) step(1'b1);
      repeat (256 * FRAME + 20) step(1'b0);
      for (int k = 0; k < 8; k++) begin
         len = $urandom_range(1, 2 * FRAME);
         repeat (len) step(1'b0);
         len = $urandom_range(1, 3);
         repeat (len) step(1'b1);
      end
      repeat (FRAME + 5) step(1'b0);
      #5;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
